// File: rtl/macplus_kbd_pkg.sv
// Shared constants, FSM state type and key-event expansion helpers for the
// Macintosh Plus keyboard protocol front end.
package macplus_kbd_pkg;

  localparam logic [7:0] CMD_INQUIRY  = 8'h10;
  localparam logic [7:0] CMD_INSTANT  = 8'h14;
  localparam logic [7:0] CMD_MODEL    = 8'h16;
  localparam logic [7:0] CMD_TEST     = 8'h36;

  localparam logic [7:0] RSP_NULL     = 8'h7B;
  localparam logic [7:0] RSP_ACK      = 8'h7D;
  localparam logic [7:0] RSP_NAK      = 8'h77;
  localparam logic [7:0] PFX_KEYPAD   = 8'h79;
  localparam logic [7:0] PFX_SHIFT_DN = 8'h71;
  localparam logic [7:0] PFX_SHIFT_UP = 8'hF1;

  localparam logic [8:0] KEY_UNMAPPED = 9'h07F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } kbd_state_e;

  // ev = {make, class[1:0], code[6:0]}; idx selects the byte within the event.
  function automatic logic [7:0] key_byte(input logic [9:0] ev, input logic [1:0] idx);
    logic [7:0] c;
    logic [7:0] b;
    c = {~ev[9], ev[6:0]};
    b = c;
    case (ev[8:7])
      2'd1: b = (idx == 2'd0) ? PFX_KEYPAD : c;
      2'd3: begin
        if (ev[9]) begin
          b = (idx == 2'd0) ? PFX_SHIFT_DN : (idx == 2'd1) ? PFX_KEYPAD : c;
        end else begin
          b = (idx == 2'd0) ? PFX_KEYPAD : (idx == 2'd1) ? c : PFX_SHIFT_UP;
        end
      end
      default: b = c;
    endcase
    return b;
  endfunction

  function automatic logic key_last(input logic [1:0] cls, input logic [1:0] idx);
    logic last;
    case (cls)
      2'd1:    last = (idx >= 2'd1);
      2'd3:    last = (idx >= 2'd2);
      default: last = 1'b1;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/macplus_kbd_if.sv
// Key-event input, host command/reply handshake and overflow status bundle.
interface macplus_kbd_if;
  logic       key_strobe;
  logic       key_make;
  logic [8:0] key_mac;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_ready;
  logic       overflow;

  modport master (
    output key_strobe, key_make, key_mac, cmd_valid, cmd_data, resp_ready,
    input  resp_valid, resp_data, overflow
  );

  modport slave (
    input  key_strobe, key_make, key_mac, cmd_valid, cmd_data, resp_ready,
    output resp_valid, resp_data, overflow
  );
endinterface

// File: rtl/macplus_kbd_event_fifo.sv
// Synchronous key-event FIFO; a push while full is taken only if a pop
// happens on the same edge.
module kbd_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (rd_en) rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/macplus_kbd.sv
// Mac Plus keyboard host-protocol engine: queues translated key events and
// answers Inquiry/Instant/Model/Test commands one reply byte at a time.
//
//   state   | meaning
//   IDLE    | waiting for a host command
//   WAIT    | Inquiry parked until a key byte arrives or the timeout expires
//   RESP    | reply byte presented, waiting for resp_ready
module macplus_kbd
  import macplus_kbd_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter int         INQ_TIMEOUT = 8000000,
  parameter logic [7:0] MODEL_ID    = 8'h0B
) (
  input logic          clk,
  input logic          rst_n,
  macplus_kbd_if.slave kbd
);

  localparam int             CW       = $clog2(INQ_TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(INQ_TIMEOUT - 1);

  logic [1:0]    rst_sync_q;
  logic          rst_int_n;

  kbd_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    bidx_q;
  logic          resp_valid_q;
  logic [7:0]    resp_data_q;
  logic          key_reply_q;
  logic          overflow_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [9:0]    fifo_dout;
  logic          have_key;
  logic [7:0]    key_byte_w;
  logic          key_last_w;

  // Assert asynchronously, release on a single clock edge for every flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign fifo_push  = kbd.key_strobe && (kbd.key_mac != KEY_UNMAPPED);
  assign have_key   = !fifo_empty;
  assign key_byte_w = key_byte(fifo_dout, bidx_q);
  assign key_last_w = key_last(fifo_dout[8:7], bidx_q);
  assign fifo_pop   = (state_q == ST_RESP) && kbd.resp_ready && key_reply_q && key_last_w;

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_int_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   ({kbd.key_make, kbd.key_mac}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (fifo_dout)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bidx_q       <= 2'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 8'h00;
      key_reply_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (kbd.cmd_valid) begin
            cnt_q       <= '0;
            key_reply_q <= 1'b0;
            case (kbd.cmd_data)
              CMD_INQUIRY: begin
                if (have_key) begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= key_byte_w;
                  key_reply_q  <= 1'b1;
                  state_q      <= ST_RESP;
                end else begin
                  state_q <= ST_WAIT;
                end
              end
              CMD_INSTANT: begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= have_key ? key_byte_w : RSP_NULL;
                key_reply_q  <= have_key;
                state_q      <= ST_RESP;
              end
              CMD_MODEL: begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= MODEL_ID;
                state_q      <= ST_RESP;
              end
              CMD_TEST: begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= RSP_ACK;
                state_q      <= ST_RESP;
              end
              default: begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= RSP_NAK;
                state_q      <= ST_RESP;
              end
            endcase
          end
        end
        ST_WAIT: begin
          // A key byte wins over the timeout when both land on the same edge.
          if (have_key) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= key_byte_w;
            key_reply_q  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= RSP_NULL;
            key_reply_q  <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          if (kbd.resp_ready) begin
            resp_valid_q <= 1'b0;
            key_reply_q  <= 1'b0;
            state_q      <= ST_IDLE;
            if (key_reply_q) bidx_q <= key_last_w ? 2'd0 : bidx_q + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                               overflow_q <= 1'b0;
    else if (fifo_push && fifo_full && !fifo_pop) overflow_q <= 1'b1;
  end

  assign kbd.resp_valid = resp_valid_q;
  assign kbd.resp_data  = resp_data_q;
  assign kbd.overflow   = overflow_q;

endmodule

// File: doc/macplus_kbd.md
MACPLUS_KBD -- requirements
Module: macplus_kbd

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: key-event queue depth, power of two.
REQ-002 SHALL have parameter INQ_TIMEOUT, default 8000000: clock cycles an Inquiry may wait before the Null reply (about 250 ms at 32 MHz).
REQ-003 SHALL have parameter MODEL_ID, default 8'h0B: Model command reply byte.
REQ-004 clk  input  1  system clock; one clock domain only.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_strobe  input  1  one-cycle pulse; a translated key event is present.
REQ-007 key_make  input  1  1 = key press, 0 = key release; sampled with key_strobe.
REQ-008 key_mac  input  9  {class[1:0], code[6:0]} from the key translation table; sampled with key_strobe.
REQ-009 cmd_valid  input  1  one-cycle pulse; host command byte received from the VIA shift register.
REQ-010 cmd_data  input  8  host command byte.
REQ-011 resp_valid  output  1  reply byte pending.
REQ-012 resp_data  output  8  reply byte; stable while resp_valid=1.
REQ-013 resp_ready  input  1  shift-out side accepts the reply.
REQ-014 overflow  output  1  sticky flag; a key event was dropped because the queue was full.

Function
REQ-015 SHALL discard, without queueing, any key_strobe whose key_mac equals {2'd0,7'h7f} (unmapped key).
REQ-016 SHALL push {key_make, key_mac} into the queue on each other key_strobe; when full, SHALL drop the event and set overflow.
REQ-017 SHALL expand each queued event into reply bytes; br = ~key_make; c = {br,code[6:0]}.
  - class 0: c.
  - class 1: 8'h79, c.
  - class 3, make: 8'h71, 8'h79, c.
  - class 3, break: 8'h79, c, 8'hF1.
  - class 2: treat as class 0.
REQ-018 SHALL pop an event only after its last reply byte has been accepted; the byte index SHALL advance once per accepted key byte.
REQ-019 SHALL decode host commands as follows.
  - 8'h10 Inquiry: reply with the next byte.
  - 8'h14 Instant: reply with the next byte, or 8'h7B if none.
  - 8'h16 Model: reply MODEL_ID.
  - 8'h36 Test: reply 8'h7D.
  - Any other byte: reply 8'h77.
REQ-020 SHALL implement FSM IDLE -> (Inquiry, nothing pending) WAIT -> RESP -> IDLE, and IDLE -> (any other command, or Inquiry with a byte pending) RESP -> IDLE.
REQ-021 In WAIT, SHALL count cycles from 0; when a byte becomes available, SHALL move to RESP with that byte on the next cycle.
REQ-022 In WAIT, SHALL move to RESP with 8'h7B when the count reaches INQ_TIMEOUT-1 with nothing pending.
REQ-023 If a byte becomes available on the same cycle the timeout fires, SHALL reply with the key byte, not 8'h7B.
REQ-024 In RESP, SHALL hold resp_valid=1 with stable resp_data until resp_ready=1, then return to IDLE on the following cycle.
REQ-025 Reply latency SHALL be 1 cycle: cmd_valid in IDLE makes resp_valid=1 on the next edge.
REQ-026 SHALL ignore cmd_valid while in WAIT or RESP; the command is not queued and the byte index does not change.
REQ-027 On a simultaneous key_strobe and pop, SHALL perform both; on a full queue with a simultaneous pop, SHALL accept the push.
REQ-028 Reply bytes 8'h7B, 8'h7D, 8'h77 and MODEL_ID SHALL NOT advance the byte index or pop the queue.
REQ-029 overflow SHALL clear only on reset.

Reset
REQ-030 rst_n low SHALL asynchronously force, regardless of any transaction in progress:
  - FSM to IDLE;
  - queue empty;
  - byte index 0;
  - timeout counter 0;
  - resp_valid=0, resp_data=8'h00, overflow=0.
REQ-031 Release of rst_n SHALL be synchronised internally so all flops leave reset on the same clk edge.

Structure
REQ-032 Package macplus_kbd_pkg SHALL hold:
  - command constants CMD_INQUIRY, CMD_INSTANT, CMD_MODEL, CMD_TEST;
  - reply constants RSP_NULL, RSP_ACK, RSP_NAK, PFX_KEYPAD, PFX_SHIFT_DN, PFX_SHIFT_UP;
  - the FSM state enum.
REQ-033 SHALL instantiate one sub-module, kbd_event_fifo: a synchronous 10-bit FIFO with push, pop, full, empty and dout.

Verification
REQ-034 Press 'a' (9'h001, make) in IDLE, then Inquiry 8'h10 -> resp_data 8'h01 one cycle later; after a second Inquiry, Instant 8'h14 -> 8'h7B.
REQ-035 Inquiry with queue empty, no key for INQ_TIMEOUT cycles -> resp_data 8'h7B exactly INQ_TIMEOUT+1 cycles after cmd_valid; key strobe at cycle 100 instead -> its byte at cycle 101.
REQ-036 Shifted keypad '=' (9'h191) make, then break, with 6 Inquiries -> bytes 71,79,11,79,91,F1 in order.
REQ-037 Push FIFO_DEPTH+1 events with no host commands -> overflow=1, and Inquiries return only the first FIFO_DEPTH events.
REQ-038 Model 8'h16 -> MODEL_ID; Test 8'h36 -> 8'h7D; 8'h55 -> 8'h77; hold resp_ready=0 for 10 cycles -> resp_data stable throughout.
REQ-039 Assert rst_n low during WAIT and during RESP with the queue non-empty -> all outputs at reset values immediately; next Inquiry waits for a new event.
